alu_operand_loader: RTL

Front-end stage feeding the ALU datapath on the FPGA board. Builds 32-bit operands A and B one byte at a time from 8 slide switches under debounced push-button control, then issues a 3-bit operation to the ALU. It waits a fixed settling time, captures the result F and the ZF/OF flags, and drives one selected result byte onto the 8 LEDs.

---
 rtl/alu_operand_loader_pkg.sv | 43 ++++
 rtl/alu_operand_loader_btn_debounce.sv | 44 ++++
 rtl/alu_operand_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM states, ALU op codes,
// datapath widths and a byte-lane merge helper.
package alu_operand_loader_pkg;

  localparam int DATA_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int OP_W     = 3;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT = 3'b110;
  localparam logic [OP_W-1:0] OP_SLL = 3'b111;

  // Replace one byte lane of a word, leaving the other lanes untouched.
  function automatic logic [DATA_W-1:0] write_lane(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] data
  );
    logic [DATA_W-1:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = data;
      2'd1:    r[15:8]  = data;
      2'd2:    r[23:16] = data;
      default: r[31:24] = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-count debouncer and a
// one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // The level flips only once the synchronized input has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      if (sync_q[1] != level) begin
        if (cnt == LAST) begin
          level <= sync_q[1];
          cnt   <= '0;
          press <= sync_q[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Switch-driven operand loader: assembles A/B byte by byte, issues an op to
// the external ALU, waits a fixed settle time and captures F and flags.
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sw,
  input  logic              sel_ab,
  input  logic [1:0]        byte_sel,
  input  logic [OP_W-1:0]   op_sw,
  input  logic [1:0]        led_sel,
  input  logic              btn_load,
  input  logic              btn_go,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zf,
  input  logic              alu_of,
  output logic [DATA_W-1:0] f_reg,
  output logic              zf_reg,
  output logic              of_reg,
  output logic [7:0]        led,
  output logic              busy,
  output state_t            dbg_state
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                load_level, load_pulse;
  logic                go_level, go_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .level (load_level),
    .press (load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_go),
    .level (go_level),
    .press (go_pulse)
  );

  // Pulses arriving outside IDLE are simply ignored, so operands stay frozen
  // for the whole operation. A load pulse wins over a coincident go pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      f_reg      <= '0;
      zf_reg     <= 1'b0;
      of_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_pulse) begin
            if (sel_ab) alu_b <= write_lane(alu_b, byte_sel, sw);
            else        alu_a <= write_lane(alu_a, byte_sel, sw);
          end else if (go_pulse) begin
            alu_op <= op_sw;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CAPTURE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        CAPTURE: begin
          f_reg  <= alu_f;
          zf_reg <= alu_zf;
          of_reg <= alu_of;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    led = f_reg[7:0];
    case (led_sel)
      2'd0:    led = f_reg[7:0];
      2'd1:    led = f_reg[15:8];
      2'd2:    led = f_reg[23:16];
      default: led = f_reg[31:24];
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
